// File: rtl/out_mem_streamer.sv
// Streams the scaled image out of the output BRAM as a valid/ready byte stream,
// keeping a running byte checksum and a beat count for host-side verification.
module out_mem_streamer #(
   parameter int AW     = 12,
   parameter int CSUM_W = 16
) (
   input  logic              clk_50,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       i_out_w,
   input  logic [15:0]       i_out_h,
   output logic [AW-1:0]     mem_raddr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              busy,
   output logic              done,
   output logic [CSUM_W-1:0] o_checksum,
   output logic [AW:0]       o_beats
);

   localparam logic [31:0] MAX_LEN = 32'd1 << AW;
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_STREAM} state_t;
   state_t r_state, w_state_next;

   logic [AW:0]       r_len, r_rd_ptr, r_beats;
   logic [CSUM_W-1:0] r_checksum;
   logic              r_inflight, r_inflight_last, r_done;
   logic [1:0]        r_count;
   logic              r_head;
   logic [7:0]        r_fifo_data [2];
   logic              r_fifo_last [2];

   logic [31:0] w_prod;
   logic [AW:0] w_len_sat;
   logic        w_valid, w_beat, w_head_last, w_issue, w_push, w_tail;
   logic        w_done_next, w_start, w_flush;

   assign w_prod      = 32'(i_out_w) * 32'(i_out_h);
   assign w_len_sat   = (w_prod > MAX_LEN) ? MAX_LEN[AW:0] : w_prod[AW:0];
   assign w_valid     = (r_count != 2'd0);
   assign w_head_last = r_fifo_last[r_head];
   assign w_beat      = w_valid & m_tready;
   assign w_push      = r_inflight;
   assign w_tail      = r_head ^ (r_count != 2'd0);
   assign w_start     = (r_state == S_IDLE) && start;
   assign w_flush     = abort && (r_state != S_IDLE);

   // Occupancy is FIFO entries plus the read in flight; a pop this cycle frees a
   // slot immediately so a depth-2 FIFO still sustains one beat per cycle.
   assign w_issue = (r_state == S_STREAM) && !abort && (r_rd_ptr < r_len) &&
                    ((r_count == 2'd0) || ((r_count == 2'd1) && !r_inflight) || w_beat);

   always_comb begin
      w_state_next = r_state;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_CALC;
         end
         S_CALC: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (w_len_sat == '0) begin
               w_state_next = S_IDLE;
               w_done_next  = 1'b1;
            end else begin
               w_state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (w_beat && w_head_last) begin
               w_state_next = S_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_done          <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_len           <= '0;
         r_rd_ptr        <= '0;
         r_checksum      <= '0;
         r_beats         <= '0;
         r_count         <= 2'd0;
         r_head          <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_done     <= w_done_next;
         r_inflight <= w_issue;
         if (w_issue) begin
            r_rd_ptr        <= r_rd_ptr + ONE;
            r_inflight_last <= (r_rd_ptr == r_len - ONE);
         end
         if (r_state == S_CALC) r_len <= w_len_sat;
         if (w_start) begin
            r_checksum <= '0;
            r_beats    <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
         end else begin
            // A beat in the abort cycle still counts; only the FIFO is flushed.
            if (w_beat) begin
               r_checksum <= r_checksum + CSUM_W'(m_tdata);
               r_beats    <= r_beats + ONE;
            end
            if (w_flush) begin
               r_count <= 2'd0;
               r_head  <= 1'b0;
            end else begin
               if (w_push && !w_beat)      r_count <= r_count + 2'd1;
               else if (!w_push && w_beat) r_count <= r_count - 2'd1;
               if (w_beat) r_head <= ~r_head;
            end
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= 8'h00;
            r_fifo_last[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_push && (w_tail == 1'(i))) begin
               r_fifo_data[i] <= mem_rdata;
               r_fifo_last[i] <= r_inflight_last;
            end
         end
      end
   end

   assign mem_raddr  = w_issue ? r_rd_ptr[AW-1:0] : '0;
   assign m_tvalid   = w_valid;
   assign m_tdata    = w_valid ? r_fifo_data[r_head] : 8'h00;
   assign m_tlast    = w_valid & w_head_last;
   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   assign o_checksum = r_checksum;
   assign o_beats    = r_beats;

endmodule

// File: tb/tb_out_mem_streamer.sv
// Bench for out_mem_streamer: a BRAM model with 1-cycle read latency feeds the
// DUT, and each job's stream is checked against a queue built from memory contents.
module tb_out_mem_streamer;
   localparam int AW     = 12;
   localparam int CSUM_W = 16;
   localparam int MEM_N  = 4096;
   localparam int LIMIT  = 12000;

   logic              clk_50 = 1'b0;
   logic              rst_n  = 1'b1;
   logic              start  = 1'b0;
   logic              abort  = 1'b0;
   logic [15:0]       i_out_w = '0;
   logic [15:0]       i_out_h = '0;
   logic [AW-1:0]     mem_raddr;
   logic [7:0]        mem_rdata;
   logic [7:0]        m_tdata;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic              m_tlast;
   logic              busy;
   logic              done;
   logic [CSUM_W-1:0] o_checksum;
   logic [AW:0]       o_beats;

   always #10 clk_50 = ~clk_50;

   logic [7:0] mem [MEM_N];
   always @(posedge clk_50) mem_rdata <= mem[mem_raddr];

   out_mem_streamer #(.AW(AW), .CSUM_W(CSUM_W)) dut (
      .clk_50(clk_50), .rst_n(rst_n), .start(start), .abort(abort),
      .i_out_w(i_out_w), .i_out_h(i_out_h),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .busy(busy), .done(done), .o_checksum(o_checksum), .o_beats(o_beats)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] got_q [$];
   logic       got_last_q [$];
   logic [7:0] exp_q [$];
   int         exp_sum;
   int first_valid_k, first_beat_k, last_beat_k, done_k, done_cnt;
   int stall_err, max_raddr, abort_bad;

   task automatic fill_index();
      for (int i = 0; i < MEM_N; i++) mem[i] = 8'(i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
   endtask

   // Reference: the stream is simply mem[0 .. min(w*h, 2^AW)-1], checksum is its byte sum.
   task automatic build_model(input int w, input int h);
      longint p;
      int     len;
      p   = longint'(w) * longint'(h);
      len = (p > MEM_N) ? MEM_N : int'(p);
      exp_q.delete();
      exp_sum = 0;
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(mem[i]);
         exp_sum = (exp_sum + int'(mem[i])) % 65536;
      end
   endtask

   function automatic int first_diff();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
      if (got_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic int last_pos();
      int pos;
      int cnt;
      pos = -1;
      cnt = 0;
      for (int i = 0; i < got_last_q.size(); i++)
         if (got_last_q[i] === 1'b1) begin pos = i; cnt++; end
      return (cnt > 1) ? -2 : pos;
   endfunction

   // Drives one job; cycle k=0 is the CALC cycle. rmode 0: ready high, 1: random.
   task automatic run_job(input int w, input int h, input int rmode,
                          input int abort_at, input logic abort_rdy, input int restart_at);
      int         k, tail;
      bit         finished, aborted, abort_chk, prev_stall;
      logic [7:0] prev_d;
      logic       prev_l;
      got_q.delete(); got_last_q.delete();
      first_valid_k = -1; first_beat_k = -1; last_beat_k = -1; done_k = -1;
      done_cnt = 0; stall_err = 0; max_raddr = 0; abort_bad = 0;
      finished = 0; aborted = 0; abort_chk = 0; prev_stall = 0; prev_d = '0; prev_l = 0;
      k = 0; tail = 0;
      @(posedge clk_50); #1;
      i_out_w = 16'(w); i_out_h = 16'(h);
      start = 1'b1;
      while (k < LIMIT && tail < 4) begin
         @(posedge clk_50); #1;
         start = 1'b0;
         abort = 1'b0;
         if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l))
            stall_err++;
         if (abort_chk && (m_tvalid !== 1'b0 || busy !== 1'b0)) abort_bad++;
         abort_chk = 0;
         if (done === 1'b1) begin done_cnt++; done_k = k; end
         if (finished) tail++;
         m_tready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (abort_at >= 0 && !aborted && got_q.size() == abort_at && m_tvalid === 1'b1) begin
            abort = 1'b1; m_tready = abort_rdy; aborted = 1; abort_chk = 1;
         end
         if (k == restart_at) start = 1'b1;
         #1;
         if (m_tvalid === 1'b1 && first_valid_k < 0) first_valid_k = k;
         if (int'(mem_raddr) > max_raddr) max_raddr = int'(mem_raddr);
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            got_q.push_back(m_tdata);
            got_last_q.push_back(m_tlast);
            if (first_beat_k < 0) first_beat_k = k;
            last_beat_k = k;
         end
         prev_stall = (m_tvalid === 1'b1) && !m_tready && !abort;
         prev_d = m_tdata; prev_l = m_tlast;
         if (!finished && k > 0 && busy === 1'b0) finished = 1;
         k++;
      end
      m_tready = 1'b0; start = 1'b0; abort = 1'b0;
      n_cmp++;
      if (k >= LIMIT) begin
         n_bad++;
         $display("FAIL job_timeout: ran %0d cycles, required finish within %0d", k, LIMIT);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_raddr, m_tdata, m_tvalid, m_tlast, busy, done, o_checksum, o_beats} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: raddr=%0h tdata=%0h tvalid=%b tlast=%b busy=%b done=%b csum=%0h beats=%0d, required all 0",
                  mem_raddr, m_tdata, m_tvalid, m_tlast, busy, done, o_checksum, o_beats);
      end
      repeat (3) @(posedge clk_50);
      @(negedge clk_50);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      fill_index();
      build_model(4, 4);
      run_job(4, 4, 0, -1, 1'b0, -1);
      n_cmp++;
      if (first_diff() !== -1) begin
         n_bad++;
         $display("FAIL basic_data: got %0d beats, first diff at %0d, required %0d beats 0..15",
                  got_q.size(), first_diff(), exp_q.size());
      end
      n_cmp++;
      if (last_pos() !== 15) begin n_bad++; $display("FAIL basic_tlast: at beat %0d, required 15", last_pos()); end
      n_cmp++;
      if (first_valid_k !== 3) begin n_bad++; $display("FAIL basic_latency: first valid cycle %0d, required 3", first_valid_k); end
      n_cmp++;
      if (last_beat_k - first_beat_k !== 15) begin
         n_bad++; $display("FAIL basic_throughput: span %0d, required 15", last_beat_k - first_beat_k);
      end
      n_cmp++;
      if (done_cnt !== 1 || done_k !== last_beat_k + 1) begin
         n_bad++; $display("FAIL basic_done: count %0d at cycle %0d, required 1 at %0d", done_cnt, done_k, last_beat_k + 1);
      end
      n_cmp++;
      if (int'(o_checksum) !== exp_sum) begin n_bad++; $display("FAIL basic_checksum: got %0d want %0d", o_checksum, exp_sum); end
      n_cmp++;
      if (int'(o_beats) !== 16) begin n_bad++; $display("FAIL basic_beats: got %0d want 16", o_beats); end
      $display("basic: %0d beats checksum %0d", got_q.size(), o_checksum);
   endtask

   task automatic test_backpressure();
      fill_index();
      build_model(4, 4);
      run_job(4, 4, 1, -1, 1'b0, -1);
      n_cmp++;
      if (first_diff() !== -1) begin
         n_bad++; $display("FAIL bp_data: got %0d beats, first diff at %0d, required 16", got_q.size(), first_diff());
      end
      n_cmp++;
      if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stall_err); end
      n_cmp++;
      if (max_raddr > 15) begin n_bad++; $display("FAIL bp_raddr: max %0d, required <= 15", max_raddr); end
      n_cmp++;
      if (done_cnt !== 1 || done_k !== last_beat_k + 1) begin
         n_bad++; $display("FAIL bp_done: count %0d at %0d, required 1 at %0d", done_cnt, done_k, last_beat_k + 1);
      end
      n_cmp++;
      if (int'(o_checksum) !== exp_sum || int'(o_beats) !== 16) begin
         n_bad++; $display("FAIL bp_totals: csum %0d beats %0d, required %0d 16", o_checksum, o_beats, exp_sum);
      end
      $display("backpressure: %0d beats checksum %0d", got_q.size(), o_checksum);
   endtask

   task automatic test_zero_len();
      run_job(0, 5, 0, -1, 1'b0, -1);
      n_cmp++;
      if (done_cnt !== 1 || done_k !== 1) begin
         n_bad++; $display("FAIL zero_done: count %0d at %0d, required 1 at 1", done_cnt, done_k);
      end
      n_cmp++;
      if (first_valid_k !== -1) begin n_bad++; $display("FAIL zero_valid: valid at %0d, required never", first_valid_k); end
      n_cmp++;
      if (o_beats !== '0) begin n_bad++; $display("FAIL zero_beats: got %0d want 0", o_beats); end
      $display("zero_len: done at cycle %0d", done_k);
   endtask

   task automatic test_saturate();
      fill_index();
      build_model(64, 128);
      run_job(64, 128, 0, -1, 1'b0, -1);
      n_cmp++;
      if (first_diff() !== -1) begin
         n_bad++; $display("FAIL sat_data: got %0d beats, first diff at %0d, required 4096", got_q.size(), first_diff());
      end
      n_cmp++;
      if (last_pos() !== 4095) begin n_bad++; $display("FAIL sat_tlast: at %0d, required 4095", last_pos()); end
      n_cmp++;
      if (int'(o_checksum) !== exp_sum) begin n_bad++; $display("FAIL sat_checksum: got %0d want %0d", o_checksum, exp_sum); end
      n_cmp++;
      if (int'(o_beats) !== 4096) begin n_bad++; $display("FAIL sat_beats: got %0d want 4096", o_beats); end
      $display("saturate: %0d beats checksum %0d", got_q.size(), o_checksum);
   endtask

   task automatic test_abort();
      fill_index();
      run_job(4, 4, 0, 7, 1'b0, -1);
      n_cmp++;
      if (got_q.size() !== 7 || abort_bad !== 0) begin
         n_bad++; $display("FAIL abort_stop: %0d beats, %0d bad post-abort cycles, required 7 and 0", got_q.size(), abort_bad);
      end
      n_cmp++;
      if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done: %0d pulses, required 0", done_cnt); end
      n_cmp++;
      if (int'(o_beats) !== 7 || int'(o_checksum) !== 21) begin
         n_bad++; $display("FAIL abort_partial: beats %0d csum %0d, required 7 21", o_beats, o_checksum);
      end
      build_model(4, 4);
      run_job(4, 4, 0, -1, 1'b0, -1);
      n_cmp++;
      if (first_diff() !== -1 || done_cnt !== 1) begin
         n_bad++; $display("FAIL abort_replay: %0d beats diff at %0d done %0d, required full replay", got_q.size(), first_diff(), done_cnt);
      end
      $display("abort: replay %0d beats checksum %0d", got_q.size(), o_checksum);
   endtask

   task automatic test_abort_last();
      fill_index();
      run_job(4, 4, 0, 15, 1'b1, -1);
      n_cmp++;
      if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_last_done: %0d pulses, required 0", done_cnt); end
      n_cmp++;
      if (int'(o_beats) !== 16 || int'(o_checksum) !== 120) begin
         n_bad++; $display("FAIL abort_last_totals: beats %0d csum %0d, required 16 120", o_beats, o_checksum);
      end
      $display("abort_last: beats %0d checksum %0d", o_beats, o_checksum);
   endtask

   task automatic test_start_busy();
      fill_index();
      build_model(4, 4);
      run_job(4, 4, 1, -1, 1'b0, 8);
      n_cmp++;
      if (first_diff() !== -1 || done_cnt !== 1 || int'(o_beats) !== 16) begin
         n_bad++; $display("FAIL start_busy: %0d beats diff %0d done %0d obeats %0d, required 16 -1 1 16",
                           got_q.size(), first_diff(), done_cnt, o_beats);
      end
      $display("start_busy: %0d beats", got_q.size());
   endtask

   task automatic test_async_reset();
      fill_index();
      @(posedge clk_50); #1;
      i_out_w = 16'd4; i_out_h = 16'd4; start = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0; m_tready = 1'b1;
      repeat (8) @(posedge clk_50);
      #5;
      n_cmp++;
      if (busy !== 1'b1 || o_beats === '0) begin
         n_bad++; $display("FAIL areset_pre: busy %b beats %0d, required busy mid-stream", busy, o_beats);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_raddr, m_tdata, m_tvalid, m_tlast, busy, done, o_checksum, o_beats} !== '0) begin
         n_bad++;
         $display("FAIL areset_outputs: raddr=%0h tdata=%0h tvalid=%b busy=%b csum=%0h beats=%0d, required all 0",
                  mem_raddr, m_tdata, m_tvalid, busy, o_checksum, o_beats);
      end
      m_tready = 1'b0;
      @(negedge clk_50);
      rst_n = 1'b1;
      build_model(4, 4);
      run_job(4, 4, 0, -1, 1'b0, -1);
      n_cmp++;
      if (first_diff() !== -1 || done_cnt !== 1) begin
         n_bad++; $display("FAIL areset_recover: %0d beats diff %0d done %0d", got_q.size(), first_diff(), done_cnt);
      end
      $display("async_reset: recovered with %0d beats", got_q.size());
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int w, h, len;
         fill_random();
         w = $urandom_range(0, 48);
         h = $urandom_range(1, 48);
         build_model(w, h);
         len = exp_q.size();
         run_job(w, h, 1, -1, 1'b0, -1);
         n_cmp++;
         if (first_diff() !== -1) begin
            n_bad++; $display("FAIL rand_data: %0dx%0d got %0d beats diff at %0d, required %0d", w, h, got_q.size(), first_diff(), len);
         end
         n_cmp++;
         if (last_pos() !== len - 1) begin n_bad++; $display("FAIL rand_tlast: at %0d, required %0d", last_pos(), len - 1); end
         n_cmp++;
         if (int'(o_checksum) !== exp_sum || int'(o_beats) !== len) begin
            n_bad++; $display("FAIL rand_totals: csum %0d beats %0d, required %0d %0d", o_checksum, o_beats, exp_sum, len);
         end
         n_cmp++;
         if (done_cnt !== 1 || stall_err !== 0 || max_raddr > ((len > 0) ? len - 1 : 0)) begin
            n_bad++; $display("FAIL rand_protocol: done %0d stalls %0d maxaddr %0d, required 1 0 <=%0d", done_cnt, stall_err, max_raddr, len - 1);
         end
         $display("random %0d: %0dx%0d -> %0d beats checksum %0d", it, w, h, got_q.size(), o_checksum);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_saturate();
      test_abort();
      test_abort_last();
      test_start_busy();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
